// File: rtl/cam_pkg.sv
// Shared types and default geometry for the CAM command sequencer.
package cam_pkg;

  localparam int unsigned CAM_NUM_ELEMS = 32;
  localparam int unsigned CAM_WORD_BITS = 5;
  localparam int unsigned CAM_WORD_SIZE = 32;

  typedef enum logic [2:0] {
    OP_READ   = 3'd0,
    OP_WRITE  = 3'd1,
    OP_SEARCH = 3'd2,
    OP_INSERT = 3'd3,
    OP_REMOVE = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

endpackage

// File: rtl/priorityencoder.sv
// Lowest-set-bit priority encoder; valid is low when no request bit is set.
module priorityencoder #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_BITS = 5
) (
  input  logic [WIDTH-1:0]    req,
  output logic [IDX_BITS-1:0] idx,
  output logic                valid
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (req[i-1]) begin
        idx   = IDX_BITS'(i - 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// CAM command sequencer: one command in flight, IDLE -> EXEC -> RESP -> IDLE,
// drives storage strobes and search key in EXEC and registers the response.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned NUM_ELEMS = CAM_NUM_ELEMS,
  parameter int unsigned WORD_BITS = CAM_WORD_BITS,
  parameter int unsigned WORD_SIZE = CAM_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [2:0]           cmd_op_i,
  input  logic [WORD_BITS-1:0] cmd_index_i,
  input  logic [WORD_SIZE-1:0] cmd_data_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic                 rsp_err_o,
  output logic [WORD_BITS-1:0] rsp_index_o,
  output logic [WORD_SIZE-1:0] rsp_data_o,
  output logic                 st_we_o,
  output logic                 st_clr_o,
  output logic [WORD_BITS-1:0] st_index_o,
  output logic [WORD_SIZE-1:0] st_data_o,
  input  logic [NUM_ELEMS-1:0] st_valid_i,
  input  logic [WORD_SIZE-1:0] st_rdata_i,
  output logic [WORD_SIZE-1:0] srch_key_o,
  input  logic                 srch_valid_i,
  input  logic [WORD_BITS-1:0] srch_index_i
);

  state_e state, state_nxt;

  logic [2:0]           lat_op;
  logic [WORD_BITS-1:0] lat_index;
  logic [WORD_SIZE-1:0] lat_data;

  logic                 free_valid;
  logic [WORD_BITS-1:0] free_index;
  logic                 idx_ok;

  logic                 exec_hit, exec_err, exec_we, exec_clr;
  logic [WORD_BITS-1:0] exec_index, exec_st_index;
  logic [WORD_SIZE-1:0] exec_data;

  priorityencoder #(
    .WIDTH    (NUM_ELEMS),
    .IDX_BITS (WORD_BITS)
  ) u_free_enc (
    .req   (~st_valid_i),
    .idx   (free_index),
    .valid (free_valid)
  );

  // A full-range index can never be out of bounds; avoid a constant compare.
  assign idx_ok = (NUM_ELEMS >= (1 << WORD_BITS)) ? 1'b1
                : (lat_index < WORD_BITS'(NUM_ELEMS));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid_i) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    exec_hit      = 1'b0;
    exec_err      = 1'b0;
    exec_we       = 1'b0;
    exec_clr      = 1'b0;
    exec_index    = '0;
    exec_data     = '0;
    exec_st_index = lat_index;
    case (lat_op)
      OP_READ: begin
        exec_index = lat_index;
        if (idx_ok) begin
          exec_hit  = st_valid_i[lat_index];
          exec_data = st_rdata_i;
        end else begin
          exec_err = 1'b1;
        end
      end
      OP_WRITE: begin
        exec_index = lat_index;
        exec_we    = idx_ok;
        exec_err   = !idx_ok;
      end
      OP_SEARCH: begin
        exec_hit   = srch_valid_i;
        exec_index = srch_valid_i ? srch_index_i : '0;
      end
      OP_INSERT: begin
        if (srch_valid_i) begin
          exec_hit   = 1'b1;
          exec_index = srch_index_i;
        end else if (free_valid) begin
          exec_we       = 1'b1;
          exec_st_index = free_index;
          exec_index    = free_index;
        end else begin
          exec_err = 1'b1;
        end
      end
      OP_REMOVE: begin
        if (srch_valid_i) begin
          exec_hit      = 1'b1;
          exec_clr      = 1'b1;
          exec_st_index = srch_index_i;
          exec_index    = srch_index_i;
        end
      end
      default: exec_err = 1'b1;
    endcase
  end

  // Strobes are gated by rst so a reset during EXEC leaves storage untouched.
  always_comb begin
    cmd_ready_o = (state == S_IDLE);
    rsp_valid_o = (state == S_RESP);
    st_we_o     = (state == S_EXEC) && !rst && exec_we;
    st_clr_o    = (state == S_EXEC) && !rst && exec_clr;
    st_index_o  = exec_st_index;
    st_data_o   = lat_data;
    srch_key_o  = lat_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_op      <= '0;
      lat_index   <= '0;
      lat_data    <= '0;
      rsp_hit_o   <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_index_o <= '0;
      rsp_data_o  <= '0;
    end else begin
      if (state == S_IDLE && cmd_valid_i) begin
        lat_op    <= cmd_op_i;
        lat_index <= cmd_index_i;
        lat_data  <= cmd_data_i;
      end
      if (state == S_EXEC) begin
        rsp_hit_o   <= exec_hit;
        rsp_err_o   <= exec_err;
        rsp_index_o <= exec_index;
        rsp_data_o  <= exec_data;
      end
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: behavioural storage/search environment plus an
// independent command-level model of CAM contents used for expectations.
module tb_cam_ctrl;
  import cam_pkg::*;

  localparam int N  = 32;
  localparam int WB = 5;
  localparam int WS = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [WB-1:0] cmd_index;
  logic [WS-1:0] cmd_data;
  logic          rsp_valid, rsp_ready, rsp_hit, rsp_err;
  logic [WB-1:0] rsp_index;
  logic [WS-1:0] rsp_data;
  logic          st_we, st_clr;
  logic [WB-1:0] st_index;
  logic [WS-1:0] st_data, st_rdata, srch_key;
  logic [N-1:0]  st_valid;
  logic          srch_valid;
  logic [WB-1:0] srch_index;

  int n_checks = 0;
  int n_err    = 0;

  cam_ctrl #(.NUM_ELEMS(N), .WORD_BITS(WB), .WORD_SIZE(WS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_index_i(cmd_index), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit),
    .rsp_err_o(rsp_err), .rsp_index_o(rsp_index), .rsp_data_o(rsp_data),
    .st_we_o(st_we), .st_clr_o(st_clr), .st_index_o(st_index), .st_data_o(st_data),
    .st_valid_i(st_valid), .st_rdata_i(st_rdata),
    .srch_key_o(srch_key), .srch_valid_i(srch_valid), .srch_index_i(srch_index)
  );

  always #5 clk = ~clk;

  // Environment: storage array and combinational search, driven by DUT strobes.
  logic [WS-1:0] env_mem [N] = '{default: '0};
  logic [N-1:0]  env_valid = '0;

  always @(posedge clk) begin
    if (st_we) begin
      env_mem[st_index]   <= st_data;
      env_valid[st_index] <= 1'b1;
    end
    if (st_clr) env_valid[st_index] <= 1'b0;
  end

  assign st_valid = env_valid;
  assign st_rdata = env_mem[st_index];

  always_comb begin
    srch_valid = 1'b0;
    srch_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (env_valid[i] && env_mem[i] == srch_key) begin
        srch_valid = 1'b1;
        srch_index = WB'(i);
      end
    end
  end

  int            we_cnt = 0, clr_cnt = 0;
  logic [WB-1:0] last_we_index, last_clr_index;
  logic [WS-1:0] last_we_data;

  always @(negedge clk) begin
    if (st_we) begin
      we_cnt++;
      last_we_index = st_index;
      last_we_data  = st_data;
    end
    if (st_clr) begin
      clr_cnt++;
      last_clr_index = st_index;
    end
  end

  // Reference model of CAM contents, updated from command semantics only.
  logic [WS-1:0] ref_mem [N];
  bit            ref_valid [N];

  function automatic int find_key(input logic [WS-1:0] k);
    for (int i = 0; i < N; i++) if (ref_valid[i] && ref_mem[i] == k) return i;
    return -1;
  endfunction

  function automatic int find_free();
    for (int i = 0; i < N; i++) if (!ref_valid[i]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  logic          r_hit, r_err;
  logic [WB-1:0] r_index;
  logic [WS-1:0] r_data;

  task automatic run_cmd(input logic [2:0] op, input logic [WB-1:0] idx,
                         input logic [WS-1:0] data, input int hold);
    logic          e_hit = 1'b0, e_err = 1'b0;
    logic [WB-1:0] e_index = '0, e_st_index = '0;
    logic [WS-1:0] e_data = '0;
    int            e_we = 0, e_clr = 0, m, w, we0, clr0;
    case (op)
      3'd0: begin e_hit = ref_valid[idx]; e_data = ref_mem[idx]; e_index = idx; end
      3'd1: begin
        e_we = 1; e_st_index = idx; e_index = idx;
        ref_mem[idx] = data; ref_valid[idx] = 1'b1;
      end
      3'd2: begin
        m = find_key(data);
        if (m >= 0) begin e_hit = 1'b1; e_index = WB'(m); end
      end
      3'd3: begin
        m = find_key(data);
        if (m >= 0) begin
          e_hit = 1'b1; e_index = WB'(m);
        end else begin
          m = find_free();
          if (m >= 0) begin
            e_we = 1; e_st_index = WB'(m); e_index = WB'(m);
            ref_mem[m] = data; ref_valid[m] = 1'b1;
          end else e_err = 1'b1;
        end
      end
      3'd4: begin
        m = find_key(data);
        if (m >= 0) begin
          e_hit = 1'b1; e_clr = 1; e_st_index = WB'(m); e_index = WB'(m);
          ref_valid[m] = 1'b0;
        end
      end
      default: e_err = 1'b1;
    endcase

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_index = idx; cmd_data = data;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    check("accept_timeout", 64'(w < 20), 64'(1));
    we0 = we_cnt; clr0 = clr_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_index = WB'($urandom); cmd_data = $urandom;
    @(negedge clk);
    check("exec_busy", 64'({cmd_ready, rsp_valid}), 64'(2'b00));
    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid), 64'(1));
    check("rsp_hit", 64'(rsp_hit), 64'(e_hit));
    check("rsp_err", 64'(rsp_err), 64'(e_err));
    check("rsp_data", 64'(rsp_data), 64'(e_data));
    if (!e_err) check("rsp_index", 64'(rsp_index), 64'(e_index));
    if (e_we != 0) check("st_we_tgt", 64'({last_we_index, last_we_data}), 64'({e_st_index, data}));
    if (e_clr != 0) check("st_clr_tgt", 64'(last_clr_index), 64'(e_st_index));
    r_hit = rsp_hit; r_err = rsp_err; r_index = rsp_index; r_data = rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("rsp_hold", 64'({cmd_ready, rsp_valid, rsp_hit, rsp_err, rsp_index, rsp_data}),
            64'({1'b0, 1'b1, e_hit, e_err, e_err ? r_index : e_index, e_data}));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("back_idle", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
    check("we_count", 64'(we_cnt - we0), 64'(e_we));
    check("clr_count", 64'(clr_cnt - clr0), 64'(e_clr));
  endtask

  initial begin
    logic [WS-1:0] key7;
    int            we0, w;
    for (int i = 0; i < N; i++) begin ref_mem[i] = '0; ref_valid[i] = 1'b0; end
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_index = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_state", 64'({cmd_ready, rsp_valid, rsp_hit, rsp_err, st_we, st_clr}),
            64'(6'b100000));
      check("reset_rsp", 64'({rsp_index, rsp_data}), 64'(0));
    end

    run_cmd(3'd1, 5'd3, 32'hDEADBEEF, 0);
    run_cmd(3'd0, 5'd3, 32'h0, 0);
    check("read_back", 64'({r_hit, r_data}), 64'({1'b1, 32'hDEADBEEF}));

    run_cmd(3'd3, 5'd0, 32'h55, 0);
    check("ins_first", 64'({r_hit, r_index}), 64'({1'b0, 5'd0}));
    run_cmd(3'd3, 5'd0, 32'h55, 0);
    check("ins_dup", 64'({r_hit, r_index}), 64'({1'b1, 5'd0}));

    run_cmd(3'd2, 5'd0, 32'h55, 5);
    run_cmd(3'd7, 5'd0, 32'h0, 2);
    check("illegal_op", 64'({r_err, r_hit}), 64'(2'b10));

    // Reset while a WRITE is in EXEC must drop it without touching storage.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_index = 5'd9; cmd_data = 32'h12345678;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    check("rst_accept_timeout", 64'(w < 20), 64'(1));
    we0 = we_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_exec_strobe", 64'({st_we, st_clr}), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_idle", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
    check("rst_no_write", 64'(we_cnt - we0), 64'(0));
    run_cmd(3'd0, 5'd9, 32'h0, 0);
    check("rst_read_miss", 64'(r_hit), 64'(0));

    for (int i = 0; i < N; i++) run_cmd(3'd3, 5'd0, 32'h1000 + 32'(i), 0);
    run_cmd(3'd3, 5'd0, 32'hCAFE0001, 0);
    check("ins_full_err", 64'({r_err, r_hit}), 64'(2'b10));
    key7 = ref_mem[7];
    run_cmd(3'd4, 5'd0, key7, 0);
    check("rem_idx7", 64'({r_hit, r_index}), 64'({1'b1, 5'd7}));
    run_cmd(3'd3, 5'd0, 32'hCAFE0002, 0);
    check("ins_reuse7", 64'({r_err, r_hit, r_index}), 64'({2'b00, 5'd7}));

    for (int t = 0; t < 150; t++) begin
      logic [2:0] op;
      logic [WS-1:0] key;
      op  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      key = ($urandom_range(0, 3) == 0) ? $urandom : 32'hA0 + 32'($urandom_range(0, 7));
      run_cmd(op, WB'($urandom), key, $urandom_range(0, 2));
    end

    for (int i = 0; i < N; i++) begin
      check("env_valid", 64'(env_valid[i]), 64'(ref_valid[i]));
      if (ref_valid[i]) check("env_data", 64'(env_mem[i]), 64'(ref_mem[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
